// File: rtl/id_ex_hazard_stage_if.sv
// Decode-to-EX bundle for id_ex_hazard_stage: ID-side operands/controls in,
// registered EX fields and fetch-control strobes out.
interface id_ex_hazard_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
);
  logic [7:0]                control_signals_in;
  logic [REG_ADDR_WIDTH-1:0] rs1_id;
  logic [REG_ADDR_WIDTH-1:0] rs2_id;
  logic [REG_ADDR_WIDTH-1:0] rd_id;
  logic [DATA_WIDTH-1:0]     rs1_data_id;
  logic [DATA_WIDTH-1:0]     rs2_data_id;
  logic                      branch_taken;
  logic                      mem_busy;
  logic [7:0]                ex_control_signals;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0]     ex_rs1_data;
  logic [DATA_WIDTH-1:0]     ex_rs2_data;
  logic                      pc_write_en;
  logic                      if_id_write_en;
  logic                      if_id_flush;
  logic                      stall_active;

  modport master (
    output control_signals_in, rs1_id, rs2_id, rd_id, rs1_data_id, rs2_data_id,
           branch_taken, mem_busy,
    input  ex_control_signals, ex_rd, ex_rs1_data, ex_rs2_data,
           pc_write_en, if_id_write_en, if_id_flush, stall_active
  );

  modport slave (
    input  control_signals_in, rs1_id, rs2_id, rd_id, rs1_data_id, rs2_data_id,
           branch_taken, mem_busy,
    output ex_control_signals, ex_rd, ex_rs1_data, ex_rs2_data,
           pc_write_en, if_id_write_en, if_id_flush, stall_active
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / taken-branch bubble insertion and
// memory-stall freeze. Optional macro HAZARD_STATS_EN adds a stall_count port.
module id_ex_hazard_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic                clk,
  input  logic                rst,
  id_ex_hazard_stage_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [2:0] FLUSH_LEN = 3'(BRANCH_PENALTY - 1);

  logic [0:0]                state;
  logic [2:0]                cnt;
  logic [7:0]                ex_ctrl_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q;
  logic [DATA_WIDTH-1:0]     ex_rs1_q;
  logic [DATA_WIDTH-1:0]     ex_rs2_q;

  logic ex_is_load;
  logic load_use;
  logic bubble;
  logic pc_we;
  logic ifid_we;
  logic ifid_fl;
  logic stall;

  assign ex_is_load = ex_ctrl_q[7] & (ex_ctrl_q[5:4] == 2'b00);
  assign load_use   = ex_is_load & ((ex_rd_q == bus.rs1_id) | (ex_rd_q == bus.rs2_id));

  // Priority: rst > mem_busy > branch/FLUSH > load_use > normal.
  always_comb begin
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    ifid_fl = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    if (!rst) begin
      if (bus.mem_busy) begin
        stall = 1'b1;
      end else if ((state == FLUSH) || bus.branch_taken) begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        ifid_fl = 1'b1;
        stall   = 1'b1;
        bubble  = 1'b1;
      end else if (load_use) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q <= '0;
      ex_rd_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
    end else if (!bus.mem_busy) begin
      if (bubble) begin
        ex_ctrl_q <= '0;
        ex_rd_q   <= '0;
        ex_rs1_q  <= '0;
        ex_rs2_q  <= '0;
      end else begin
        ex_ctrl_q <= bus.control_signals_in;
        ex_rd_q   <= bus.rd_id;
        ex_rs1_q  <= bus.rs1_data_id;
        ex_rs2_q  <= bus.rs2_data_id;
      end
    end
  end

  // cnt holds the bubbles still owed after the current FLUSH cycle plus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!bus.mem_busy) begin
      if (state == FLUSH) begin
        if (cnt == 3'd1) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end else if (bus.branch_taken && (BRANCH_PENALTY > 1)) begin
        state <= FLUSH;
        cnt   <= FLUSH_LEN;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (bubble && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

  assign bus.ex_control_signals = ex_ctrl_q;
  assign bus.ex_rd              = ex_rd_q;
  assign bus.ex_rs1_data        = ex_rs1_q;
  assign bus.ex_rs2_data        = ex_rs2_q;
  assign bus.pc_write_en        = pc_we;
  assign bus.if_id_write_en     = ifid_we;
  assign bus.if_id_flush        = ifid_fl;
  assign bus.stall_active       = stall;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed vector table, reset
// corners, and randomized traffic against a cycle-level behavioural model.
module tb_id_ex_hazard_stage;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int PEN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_hazard_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  id_ex_hazard_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .BRANCH_PENALTY(PEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: contents of EX plus number of flush bubbles still owed.
  logic [7:0]    m_ctrl;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_d1, m_d2;
  int            m_flush_left;
  int            m_stats;

  typedef struct {
    logic [7:0] ctrl;
    int         rs1, rs2, rd;
    logic       br, busy;
    logic [7:0] e_ex;
    logic [3:0] e_flags; // {pc_write_en, if_id_write_en, if_id_flush, stall_active}
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_rd = '0; m_d1 = '0; m_d2 = '0;
    m_flush_left = 0;
    m_stats = 0;
  endtask

  task automatic drive(input logic [7:0] c, input int r1, input int r2, input int rd,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic br, input logic busy);
    bus.control_signals_in = c;
    bus.rs1_id       = AW'(r1);
    bus.rs2_id       = AW'(r2);
    bus.rd_id        = AW'(rd);
    bus.rs1_data_id  = a;
    bus.rs2_data_id  = b;
    bus.branch_taken = br;
    bus.mem_busy     = busy;
  endtask

  // Compare the DUT with the model for the inputs now applied, then advance
  // the model to what EX should hold after the coming rising edge.
  task automatic model_check();
    logic is_load, lu, bub, cap;
    logic [3:0] e;
    is_load = m_ctrl[7] && (m_ctrl[5:4] == 2'b00);
    lu  = is_load && ((m_rd == bus.rs1_id) || (m_rd == bus.rs2_id));
    bub = 1'b0;
    cap = 1'b0;
    if (bus.mem_busy) begin
      e = 4'b0001;
    end else if ((m_flush_left > 0) || bus.branch_taken) begin
      e = 4'b1111; bub = 1'b1;
    end else if (lu) begin
      e = 4'b0001; bub = 1'b1;
    end else begin
      e = 4'b1100; cap = 1'b1;
    end
    chk("ex_control_signals", 32'(bus.ex_control_signals), 32'(m_ctrl));
    chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
    chk("ex_rs1_data", bus.ex_rs1_data, m_d1);
    chk("ex_rs2_data", bus.ex_rs2_data, m_d2);
    chk("pc_write_en", 32'(bus.pc_write_en), 32'(e[3]));
    chk("if_id_write_en", 32'(bus.if_id_write_en), 32'(e[2]));
    chk("if_id_flush", 32'(bus.if_id_flush), 32'(e[1]));
    chk("stall_active", 32'(bus.stall_active), 32'(e[0]));
`ifdef HAZARD_STATS_EN
    chk("stall_count", 32'(stall_count), 32'(m_stats));
`endif
    if (bub) begin
      if (m_flush_left > 0) m_flush_left--;
      else if (bus.branch_taken) m_flush_left = PEN - 1;
      m_ctrl = '0; m_rd = '0; m_d1 = '0; m_d2 = '0;
      if (m_stats < 65535) m_stats++;
    end else if (cap) begin
      m_ctrl = bus.control_signals_in;
      m_rd   = bus.rd_id;
      m_d1   = bus.rs1_data_id;
      m_d2   = bus.rs2_data_id;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ex_ctrl"}, 32'(bus.ex_control_signals), 32'h0);
    chk({tag, "_ex_rd"}, 32'(bus.ex_rd), 32'h0);
    chk({tag, "_ex_rs1"}, bus.ex_rs1_data, 32'h0);
    chk({tag, "_ex_rs2"}, bus.ex_rs2_data, 32'h0);
    chk({tag, "_flags"}, 32'({bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush, bus.stall_active}), 32'h0);
  endtask

  task automatic rand_drive(input logic allow_ctl);
    logic [7:0] c;
    c = ($urandom_range(0, 2) == 0) ? 8'h81 : 8'($urandom);
    drive(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          $urandom, $urandom,
          allow_ctl && ($urandom_range(0, 9) == 0),
          allow_ctl && ($urandom_range(0, 6) == 0));
  endtask

  initial begin
    // ctrl, rs1, rs2, rd, br, busy, expected EX ctrl, expected flags
    tbl[0]  = '{8'h91, 1, 2, 5, 1'b0, 1'b0, 8'h00, 4'b1100}; // after reset release
    tbl[1]  = '{8'h81, 1, 2, 3, 1'b0, 1'b0, 8'h91, 4'b1100}; // ldr r3 in ID
    tbl[2]  = '{8'h91, 3, 6, 7, 1'b0, 1'b0, 8'h81, 4'b0001}; // add uses r3: load-use
    tbl[3]  = '{8'h91, 3, 6, 7, 1'b0, 1'b0, 8'h00, 4'b1100}; // bubble in EX
    tbl[4]  = '{8'h81, 1, 2, 3, 1'b0, 1'b0, 8'h91, 4'b1100}; // add in EX; ldr r3 in ID
    tbl[5]  = '{8'h91, 4, 5, 8, 1'b0, 1'b0, 8'h81, 4'b1100}; // independent add: no hazard
    tbl[6]  = '{8'h91, 0, 0, 1, 1'b0, 1'b0, 8'h91, 4'b1100};
    tbl[7]  = '{8'h91, 0, 0, 1, 1'b1, 1'b0, 8'h91, 4'b1111}; // taken branch
    tbl[8]  = '{8'h91, 0, 0, 2, 1'b0, 1'b0, 8'h00, 4'b1111}; // second flush cycle
    tbl[9]  = '{8'h91, 0, 0, 2, 1'b0, 1'b0, 8'h00, 4'b1100};
    tbl[10] = '{8'h91, 0, 0, 2, 1'b0, 1'b0, 8'h91, 4'b1100};
    tbl[11] = '{8'h22, 0, 0, 2, 1'b1, 1'b1, 8'h91, 4'b0001}; // freeze, branch ignored
    tbl[12] = '{8'h22, 0, 0, 2, 1'b1, 1'b1, 8'h91, 4'b0001};
    tbl[13] = '{8'h22, 0, 0, 2, 1'b1, 1'b1, 8'h91, 4'b0001};
    tbl[14] = '{8'h22, 0, 0, 2, 1'b1, 1'b1, 8'h91, 4'b0001};
    tbl[15] = '{8'h22, 0, 0, 2, 1'b1, 1'b0, 8'h91, 4'b1111}; // branch acted on
    tbl[16] = '{8'h22, 0, 0, 2, 1'b0, 1'b0, 8'h00, 4'b1111};
    tbl[17] = '{8'h91, 0, 0, 2, 1'b0, 1'b0, 8'h00, 4'b1100};

    rst = 1'b1;
    rand_drive(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_drive(1'b1);
      #1;
      chk_reset_state("reset");
    end
    model_reset();

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            32'(i * 17 + 3), 32'(i * 5 + 100), tbl[i].br, tbl[i].busy);
      #1;
      chk($sformatf("vec%0d_ex_ctrl", i), 32'(bus.ex_control_signals), 32'(tbl[i].e_ex));
      chk($sformatf("vec%0d_flags", i),
          32'({bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush, bus.stall_active}),
          32'(tbl[i].e_flags));
      model_check();
      @(posedge clk);
    end
`ifdef HAZARD_STATS_EN
    #1;
    chk("stall_count_directed", 32'(stall_count), 32'd5);
`endif

    // Reset arriving mid-FLUSH must return to RUN with everything cleared.
    @(negedge clk);
    drive(8'h91, 0, 0, 1, 32'h1234, 32'h5678, 1'b1, 1'b0);
    #1;
    model_check();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_state("midflush");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h91, 0, 0, 1, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0);
    #1;
    model_check();
    @(posedge clk);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rand_drive(1'b1);
      #1;
      model_check();
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register plus hazard control, sitting directly downstream of the decode control unit.
- Captures the 8-bit packed control word {wre, write_memory_enable, select_writeback_data_mux[1:0], aluOp[3:0]} with register indices and operands.
- Detects load-use hazards and taken branches, and inserts bubbles (all-zero control word = nop) into EX.
- Drives PC / IF-ID hold and flush.

Parameters:
- DATA_WIDTH, 32, operand width.
- REG_ADDR_WIDTH, 4, register index width.
- BRANCH_PENALTY, 2, bubble cycles per taken branch, including the detection cycle; legal range 1..7.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
control_signals_in  in  8  packed control word from decode
rs1_id  in  REG_ADDR_WIDTH  source register 1 index in ID
rs2_id  in  REG_ADDR_WIDTH  source register 2 index in ID
rd_id  in  REG_ADDR_WIDTH  destination index in ID
rs1_data_id  in  DATA_WIDTH  operand 1 from register file
rs2_data_id  in  DATA_WIDTH  operand 2 from register file
branch_taken  in  1  EX-stage branch resolved taken (be)
mem_busy  in  1  memory stall request; freezes the pipeline
ex_control_signals  out  8  registered control word to EX
ex_rd  out  REG_ADDR_WIDTH  registered destination index
ex_rs1_data  out  DATA_WIDTH  registered operand 1
ex_rs2_data  out  DATA_WIDTH  registered operand 2
pc_write_en  out  1  PC may advance/load
if_id_write_en  out  1  IF/ID register may load
if_id_flush  out  1  IF/ID register clears to nop
stall_active  out  1  high while any stall or flush is in effect

Behaviour:
- Reset is asynchronous, active-high.
  - While rst=1: all registered outputs are 0; state=RUN; counter=0.
  - Combinational outputs while rst=1: pc_write_en=0, if_id_write_en=0, if_id_flush=0, stall_active=0.
- Load detection: ex_is_load = ex_control_signals[7] & (ex_control_signals[5:4]==2'b00). For ldr, ex_control_signals = 8'h81.
- load_use = ex_is_load & ((ex_rd==rs1_id) | (ex_rd==rs2_id)).
  - Both sources are compared for every opcode (conservative).
  - Register 0 is not special.
- FSM states: RUN, FLUSH. Priority per cycle: rst > mem_busy > branch_taken/FLUSH > load_use > normal.
- mem_busy=1 (either state):
  - ID/EX registers, state and counter hold.
  - pc_write_en=0, if_id_write_en=0, if_id_flush=0, stall_active=1.
  - branch_taken is ignored that cycle; EX is also frozen, so it re-presents next cycle.
- RUN, branch_taken=1:
  - Bubble loaded into ID/EX: control=0, ex_rd=0, data=0.
  - if_id_flush=1, pc_write_en=1 (target load), if_id_write_en=1, stall_active=1.
  - If BRANCH_PENALTY>1: next state FLUSH, counter=BRANCH_PENALTY-1.
- FLUSH:
  - Bubble loaded, if_id_flush=1, pc_write_en=1, if_id_write_en=1, stall_active=1.
  - Counter decrements; at counter==1 the next state is RUN.
  - branch_taken and load_use are ignored (EX holds bubbles).
- RUN, load_use=1, no branch:
  - Bubble loaded; pc_write_en=0, if_id_write_en=0, if_id_flush=0, stall_active=1.
  - The following cycle the load has left EX, so the hazard clears naturally. Latency penalty is exactly one cycle.
- RUN, normal:
  - ID/EX captures all inputs on the clock edge; one-cycle latency.
  - pc_write_en=1, if_id_write_en=1, if_id_flush=0, stall_active=0.
- Control outputs are combinational from state and inputs; data outputs are registered only.
- rst asserted mid-FLUSH: immediate return to RUN, counter cleared, registers zeroed.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds output stall_count (16 bits), cleared by rst.
  - Increments by 1 on each clock edge where a bubble is inserted (load_use or flush).
  - Saturates at 16'hFFFF.
  - Does not count mem_busy cycles.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs -> all ex_* outputs 0, pc_write_en=0; after release with control 8'h91 -> ex_control_signals=8'h91 one edge later.
- Load-use: ID holds ldr (8'h81, rd_id=3), next ID holds add with rs1_id=3 -> one bubble (ex_control_signals=8'h00), pc_write_en=0 and if_id_write_en=0 for exactly 1 cycle, then add reaches EX.
- No false hazard: ldr rd=3 followed by add with rs1=4, rs2=5 -> no bubble; stall_active stays 0.
- Branch, BRANCH_PENALTY=2: pulse branch_taken 1 cycle -> if_id_flush=1 for 2 consecutive cycles, 2 bubbles into EX, pc_write_en=1 throughout.
- Freeze: mem_busy=1 for 4 cycles while ex_control_signals=8'h91 -> outputs hold 8'h91, all enables 0; a simultaneous branch_taken is acted on in the first cycle after mem_busy drops.
- HAZARD_STATS_EN: 3 load-use stalls plus 1 taken branch (penalty 2) -> stall_count=5; mem_busy cycles are not counted.
